// File: rtl/control_unit.sv
// RV32I main decoder: turns opcode/funct3/funct7 into datapath selects, ALU op
// and memory/writeback/branch strobes, all registered for one cycle of latency.
module control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] mem_to_reg,
    output logic [3:0] alu_control,
    output logic       regwrite,
    output logic       mem_read,
    output logic       mem_write,
    output logic       branch,
    output logic       jump
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_SLL   = 4'b0100;
    localparam logic [3:0] ALU_SLTU  = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_INV   = 4'b1111;

    localparam logic [1:0] SRC_A_RS1  = 2'b00;
    localparam logic [1:0] SRC_A_PC   = 2'b01;
    localparam logic [1:0] SRC_A_ZERO = 2'b10;
    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] WB_ALU     = 2'b00;
    localparam logic [1:0] WB_LOAD    = 2'b01;
    localparam logic [1:0] WB_PC4     = 2'b10;

    logic [1:0] alu_src_a_d,   alu_src_a_q;
    logic [1:0] alu_src_b_d,   alu_src_b_q;
    logic [1:0] mem_to_reg_d,  mem_to_reg_q;
    logic [3:0] alu_control_d, alu_control_q;
    logic       regwrite_d,    regwrite_q;
    logic       mem_read_d,    mem_read_q;
    logic       mem_write_d,   mem_write_q;
    logic       branch_d,      branch_q;
    logic       jump_d,        jump_q;

    logic [3:0] base_op;
    logic [3:0] branch_op;

    // Shared funct3 map for R-type with funct7=0 and I-type arithmetic.
    always_comb begin
        base_op = ALU_ADD;
        case (funct3)
            3'b000:  base_op = ALU_ADD;
            3'b001:  base_op = ALU_SLL;
            3'b010:  base_op = ALU_SLT;
            3'b011:  base_op = ALU_SLTU;
            3'b100:  base_op = ALU_XOR;
            3'b101:  base_op = ALU_SRL;
            3'b110:  base_op = ALU_OR;
            default: base_op = ALU_AND;
        endcase
    end

    always_comb begin
        branch_op = ALU_INV;
        case (funct3)
            3'b000, 3'b001: branch_op = ALU_SUB;
            3'b100, 3'b101: branch_op = ALU_SLT;
            3'b110, 3'b111: branch_op = ALU_SLTU;
            default:        branch_op = ALU_INV;
        endcase
    end

    // Any unrecognised encoding leaves the safe default set untouched.
    always_comb begin
        alu_src_a_d   = SRC_A_RS1;
        alu_src_b_d   = SRC_B_RS2;
        mem_to_reg_d  = WB_ALU;
        alu_control_d = ALU_INV;
        regwrite_d    = 1'b0;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        branch_d      = 1'b0;
        jump_d        = 1'b0;

        case (opcode)
            OP_R: begin
                if (funct7 == F7_BASE) begin
                    alu_control_d = base_op;
                    regwrite_d    = 1'b1;
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    alu_control_d = ALU_SUB;
                    regwrite_d    = 1'b1;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    alu_control_d = ALU_SRA;
                    regwrite_d    = 1'b1;
                end
            end
            OP_I_ALU: begin
                if (funct3 != 3'b101 || funct7 == F7_BASE || funct7 == F7_ALT) begin
                    alu_src_b_d   = SRC_B_IMM;
                    regwrite_d    = 1'b1;
                    alu_control_d = (funct3 == 3'b101 && funct7 == F7_ALT) ? ALU_SRA : base_op;
                end
            end
            OP_LOAD: begin
                alu_src_b_d   = SRC_B_IMM;
                mem_to_reg_d  = WB_LOAD;
                alu_control_d = ALU_ADD;
                regwrite_d    = 1'b1;
                mem_read_d    = 1'b1;
            end
            OP_STORE: begin
                alu_src_b_d   = SRC_B_IMM;
                alu_control_d = ALU_ADD;
                mem_write_d   = 1'b1;
            end
            OP_BRANCH: begin
                if (branch_op != ALU_INV) begin
                    alu_control_d = branch_op;
                    branch_d      = 1'b1;
                end
            end
            OP_LUI: begin
                alu_src_a_d   = SRC_A_ZERO;
                alu_src_b_d   = SRC_B_IMM;
                alu_control_d = ALU_ADD;
                regwrite_d    = 1'b1;
            end
            OP_AUIPC: begin
                alu_src_a_d   = SRC_A_PC;
                alu_src_b_d   = SRC_B_IMM;
                alu_control_d = ALU_ADD;
                regwrite_d    = 1'b1;
            end
            OP_JAL: begin
                alu_src_a_d   = SRC_A_PC;
                alu_src_b_d   = SRC_B_IMM;
                mem_to_reg_d  = WB_PC4;
                alu_control_d = ALU_ADD;
                regwrite_d    = 1'b1;
                jump_d        = 1'b1;
            end
            OP_JALR: begin
                alu_src_b_d   = SRC_B_IMM;
                mem_to_reg_d  = WB_PC4;
                alu_control_d = ALU_ADD;
                regwrite_d    = 1'b1;
                jump_d        = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_src_a_q   <= SRC_A_RS1;
            alu_src_b_q   <= SRC_B_RS2;
            mem_to_reg_q  <= WB_ALU;
            alu_control_q <= ALU_INV;
            regwrite_q    <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            branch_q      <= 1'b0;
            jump_q        <= 1'b0;
        end else begin
            alu_src_a_q   <= alu_src_a_d;
            alu_src_b_q   <= alu_src_b_d;
            mem_to_reg_q  <= mem_to_reg_d;
            alu_control_q <= alu_control_d;
            regwrite_q    <= regwrite_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            branch_q      <= branch_d;
            jump_q        <= jump_d;
        end
    end

    assign alu_src_a   = alu_src_a_q;
    assign alu_src_b   = alu_src_b_q;
    assign mem_to_reg  = mem_to_reg_q;
    assign alu_control = alu_control_q;
    assign regwrite    = regwrite_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign branch      = branch_q;
    assign jump        = jump_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed decode cases plus randomized instructions
// compared against a table-driven reference decoder.
module tb_control_unit;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] mem_to_reg;
    logic [3:0] alu_control;
    logic       regwrite;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;

    int errors = 0;
    int checks = 0;

    // Packed view: {a, b, wb, alu, regwrite, mem_read, mem_write, branch, jump}
    localparam logic [14:0] DEFAULT_SET = 15'b00_00_00_1111_00000;

    logic [3:0] alu_by_f3    [8] = '{4'h2, 4'h4, 4'h7, 4'h5, 4'h3, 4'h8, 4'h1, 4'h0};
    logic [3:0] branch_by_f3 [8] = '{4'h6, 4'h6, 4'hF, 4'hF, 4'h7, 4'h7, 4'h5, 4'h5};
    logic [6:0] legal_ops    [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                     7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                                     7'b1100111};

    control_unit dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7     (funct7),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .mem_to_reg (mem_to_reg),
        .alu_control(alu_control),
        .regwrite   (regwrite),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .branch     (branch),
        .jump       (jump)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [14:0] ref_decode(input logic r, input logic [6:0] op,
                                               input logic [2:0] f3, input logic [6:0] f7);
        logic [1:0] a, b, wb;
        logic [3:0] alu;
        logic rw, mr, mw, br, j, ok;
        a = 2'd0; b = 2'd0; wb = 2'd0; alu = 4'hF;
        rw = 0; mr = 0; mw = 0; br = 0; j = 0; ok = 1;
        if (r) return DEFAULT_SET;
        case (op)
            7'b0110011: begin
                rw = 1;
                if (f7 == 7'd0) alu = alu_by_f3[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) alu = 4'h6;
                else if (f7 == 7'h20 && f3 == 3'd5) alu = 4'h9;
                else ok = 0;
            end
            7'b0010011: begin
                b = 2'd1; rw = 1; alu = alu_by_f3[f3];
                if (f3 == 3'd5) begin
                    if (f7 == 7'h20) alu = 4'h9;
                    else if (f7 != 7'd0) ok = 0;
                end
            end
            7'b0000011: begin b = 2'd1; wb = 2'd1; alu = 4'h2; rw = 1; mr = 1; end
            7'b0100011: begin b = 2'd1; alu = 4'h2; mw = 1; end
            7'b1100011: begin
                br = 1; alu = branch_by_f3[f3];
                if (alu == 4'hF) ok = 0;
            end
            7'b0110111: begin a = 2'd2; b = 2'd1; alu = 4'h2; rw = 1; end
            7'b0010111: begin a = 2'd1; b = 2'd1; alu = 4'h2; rw = 1; end
            7'b1101111: begin a = 2'd1; b = 2'd1; wb = 2'd2; alu = 4'h2; rw = 1; j = 1; end
            7'b1100111: begin b = 2'd1; wb = 2'd2; alu = 4'h2; rw = 1; j = 1; end
            default: ok = 0;
        endcase
        if (!ok) return DEFAULT_SET;
        return {a, b, wb, alu, rw, mr, mw, br, j};
    endfunction

    function automatic logic [14:0] observed();
        return {alu_src_a, alu_src_b, mem_to_reg, alu_control,
                regwrite, mem_read, mem_write, branch, jump};
    endfunction

    task automatic checkOutput(input string tag, input logic [14:0] got, input logic [14:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=%b expected=%b", tag, got, exp);
        end
    endtask

    // Drives one instruction, lets it cross a clock edge, then samples 1 ns later.
    task automatic applyStimulus(input logic r, input logic [6:0] op,
                                 input logic [2:0] f3, input logic [6:0] f7);
        rst    = r;
        opcode = op;
        funct3 = f3;
        funct7 = f7;
        @(posedge clk);
        #1;
    endtask

    task automatic run_directed(input string tag, input logic r, input logic [6:0] op,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic [14:0] exp);
        applyStimulus(r, op, f3, f7);
        checkOutput(tag, observed(), exp);
        checkOutput({tag, "_model"}, ref_decode(r, op, f3, f7), exp);
    endtask

    initial begin
        rst = 1'b1; opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
        $display("[TB] starting control_unit bench");

        run_directed("reset",     1, 7'b0110011, 3'd0, 7'h20, DEFAULT_SET);
        run_directed("r_sub",     0, 7'b0110011, 3'd0, 7'h20, 15'b00_00_00_0110_10000);
        run_directed("r_or",      0, 7'b0110011, 3'd6, 7'h00, 15'b00_00_00_0001_10000);
        run_directed("r_srl",     0, 7'b0110011, 3'd5, 7'h00, 15'b00_00_00_1000_10000);
        run_directed("r_sra",     0, 7'b0110011, 3'd5, 7'h20, 15'b00_00_00_1001_10000);
        run_directed("r_bad_f7",  0, 7'b0110011, 3'd1, 7'h20, DEFAULT_SET);
        run_directed("lh",        0, 7'b0000011, 3'd1, 7'h55, 15'b00_01_01_0010_11000);
        run_directed("andi",      0, 7'b0010011, 3'd7, 7'h00, 15'b00_01_00_0000_10000);
        run_directed("addi_f7",   0, 7'b0010011, 3'd0, 7'h7F, 15'b00_01_00_0010_10000);
        run_directed("srai",      0, 7'b0010011, 3'd5, 7'h20, 15'b00_01_00_1001_10000);
        run_directed("sri_bad",   0, 7'b0010011, 3'd5, 7'h01, DEFAULT_SET);
        run_directed("sh",        0, 7'b0100011, 3'd1, 7'h00, 15'b00_01_00_0010_00100);
        run_directed("beq",       0, 7'b1100011, 3'd0, 7'h00, 15'b00_00_00_0110_00010);
        run_directed("bltu",      0, 7'b1100011, 3'd6, 7'h00, 15'b00_00_00_0101_00010);
        run_directed("br_bad",    0, 7'b1100011, 3'd2, 7'h00, DEFAULT_SET);
        run_directed("lui",       0, 7'b0110111, 3'd3, 7'h11, 15'b10_01_00_0010_10000);
        run_directed("auipc",     0, 7'b0010111, 3'd0, 7'h00, 15'b01_01_00_0010_10000);
        run_directed("jal",       0, 7'b1101111, 3'd0, 7'h00, 15'b01_01_10_0010_10001);
        run_directed("jalr",      0, 7'b1100111, 3'd0, 7'h00, 15'b00_01_10_0010_10001);
        run_directed("bad_op",    0, 7'b1111111, 3'd0, 7'h00, DEFAULT_SET);
        run_directed("pre_rst",   0, 7'b0110011, 3'd0, 7'h20, 15'b00_00_00_0110_10000);
        run_directed("mid_rst",   1, 7'b0110011, 3'd0, 7'h20, DEFAULT_SET);
        run_directed("post_rst",  0, 7'b0110011, 3'd0, 7'h20, 15'b00_00_00_0110_10000);

        for (int i = 0; i < 400; i++) begin
            logic [6:0] op, f7;
            logic [2:0] f3;
            logic       r;
            int         pick;
            pick = int'($urandom_range(0, 11));
            op   = (pick < 9) ? legal_ops[pick] : 7'($urandom);
            f3   = 3'($urandom);
            case ($urandom_range(0, 2))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            r = ($urandom_range(0, 19) == 0);
            applyStimulus(r, op, f3, f7);
            checkOutput("random", observed(), ref_decode(r, op, f3, f7));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
